// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with sync clear, checked parallel load, wrap or saturate at range ends.
// Latency: 1 cycle from command edge to count/pulse outputs; at_max/at_zero decode the count register.
// Backpressure: none; one command is accepted on every rising edge, with priority clr > load > inc^dec.
module bcd_counter #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                inc,
    input  logic                dec,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap_up,
    output logic                wrap_dn,
    output logic                load_err,
    output logic                at_max,
    output logic                at_zero
);

    localparam int W = 4 * DIGITS;

    // Per-digit decode of the current count and of the load word
    logic [DIGITS-1:0] dig_max;
    logic [DIGITS-1:0] dig_zero;
    logic [DIGITS-1:0] dig_ok;

    // Incremented and decremented versions of count (ripple within one cycle)
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;

    // Next-state values for the registered outputs
    logic [W-1:0] count_nxt;
    logic         wrap_up_nxt;
    logic         wrap_dn_nxt;
    logic         load_err_nxt;

    // Single-command decode: inc and dec together cancel out
    logic do_inc;
    logic do_dec;
    logic load_ok;

    assign do_inc  = inc & ~dec;
    assign do_dec  = dec & ~inc;
    assign load_ok = &dig_ok;

    // Flag each digit that is at 9, at 0, or (for the load word) a legal BCD digit
    always_comb begin
        dig_max  = '0;
        dig_zero = '0;
        dig_ok   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_max[k]  = (count[4*k +: 4] == 4'd9);
            dig_zero[k] = (count[4*k +: 4] == 4'd0);
            dig_ok[k]   = (load_val[4*k +: 4] <= 4'd9);
        end
    end

    // Carry ripple: a digit steps only when every lower digit is at 9
    always_comb begin
        logic       carry;
        logic [3:0] cur;
        inc_val = count;
        carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            cur = count[4*k +: 4];
            if (carry) begin
                inc_val[4*k +: 4] = dig_max[k] ? 4'd0 : cur + 4'd1;
            end
            carry = carry & dig_max[k];
        end
    end

    // Borrow ripple: a digit steps only when every lower digit is at 0
    always_comb begin
        logic       borrow;
        logic [3:0] cur;
        dec_val = count;
        borrow  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            cur = count[4*k +: 4];
            if (borrow) begin
                dec_val[4*k +: 4] = dig_zero[k] ? 4'd9 : cur - 4'd1;
            end
            borrow = borrow & dig_zero[k];
        end
    end

    // Range-end decode from the register only, never from the inputs
    assign at_max  = &dig_max;
    assign at_zero = &dig_zero;

    // Command priority and the wrap/saturate decision at the range ends
    always_comb begin
        count_nxt    = count;
        wrap_up_nxt  = 1'b0;
        wrap_dn_nxt  = 1'b0;
        load_err_nxt = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            // An illegal digit leaves the count untouched so it always stays valid BCD
            if (load_ok) begin
                count_nxt = load_val;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (do_inc) begin
            wrap_up_nxt = at_max;
            // inc_val is already all-zero when count is all-9s, so wrapping needs no extra case
            if (!(at_max && SATURATE)) begin
                count_nxt = inc_val;
            end
        end else if (do_dec) begin
            wrap_dn_nxt = at_zero;
            // dec_val is already all-9s when count is zero
            if (!(at_zero && SATURATE)) begin
                count_nxt = dec_val;
            end
        end
    end

    // State and pulse registers; reset truncates any pulse in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            wrap_up  <= wrap_up_nxt;
            wrap_dn  <= wrap_dn_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_counter.sv
// Directed and model-checked bench for bcd_counter in four configurations.
// Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
// All comparisons go through chk(), which steps checks/failures.
module tb_bcd_counter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DIGITS=4, wrap mode
    logic        a_clr, a_load, a_inc, a_dec;
    logic [15:0] a_val, a_cnt;
    logic        a_wu, a_wd, a_le, a_max, a_zero;
    // DIGITS=2, saturate mode
    logic        b_clr, b_load, b_inc, b_dec;
    logic [7:0]  b_val, b_cnt;
    logic        b_wu, b_wd, b_le, b_max, b_zero;
    // DIGITS=3, shared random stimulus, wrap (w_) and saturate (s_)
    logic        r_clr, r_load, r_inc, r_dec;
    logic [11:0] r_val, w_cnt, s_cnt;
    logic        w_wu, w_wd, w_le, w_max, w_zero;
    logic        s_wu, s_wd, s_le, s_max, s_zero;

    bcd_counter #(.DIGITS(4), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset_n(reset_n), .clr(a_clr), .load(a_load), .load_val(a_val),
        .inc(a_inc), .dec(a_dec), .count(a_cnt), .wrap_up(a_wu), .wrap_dn(a_wd),
        .load_err(a_le), .at_max(a_max), .at_zero(a_zero));

    bcd_counter #(.DIGITS(2), .SATURATE(1'b1)) u_b (
        .clk(clk), .reset_n(reset_n), .clr(b_clr), .load(b_load), .load_val(b_val),
        .inc(b_inc), .dec(b_dec), .count(b_cnt), .wrap_up(b_wu), .wrap_dn(b_wd),
        .load_err(b_le), .at_max(b_max), .at_zero(b_zero));

    bcd_counter #(.DIGITS(3), .SATURATE(1'b0)) u_w (
        .clk(clk), .reset_n(reset_n), .clr(r_clr), .load(r_load), .load_val(r_val),
        .inc(r_inc), .dec(r_dec), .count(w_cnt), .wrap_up(w_wu), .wrap_dn(w_wd),
        .load_err(w_le), .at_max(w_max), .at_zero(w_zero));

    bcd_counter #(.DIGITS(3), .SATURATE(1'b1)) u_s (
        .clk(clk), .reset_n(reset_n), .clr(r_clr), .load(r_load), .load_val(r_val),
        .inc(r_inc), .dec(r_dec), .count(s_cnt), .wrap_up(s_wu), .wrap_dn(s_wd),
        .load_err(s_le), .at_max(s_max), .at_zero(s_zero));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 3-digit BCD helpers for the decimal model
    function automatic bit bcd_ok(input logic [11:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
    endfunction

    function automatic int bcd_to_int(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [11:0] int_to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'(n / 100);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    // Decimal reference: returns next value, p = {wrap_up, wrap_dn, load_err}
    function automatic int model(input int m, input bit sat, input logic c, input logic ld,
                                 input logic [11:0] v, input logic i, input logic d,
                                 output logic [2:0] p);
        p = 3'b000;
        if (c) return 0;
        if (ld) begin
            if (bcd_ok(v)) return bcd_to_int(v);
            p[0] = 1'b1;
            return m;
        end
        if (i && !d) begin
            if (m == 999) begin
                p[2] = 1'b1;
                return sat ? 999 : 0;
            end
            return m + 1;
        end
        if (d && !i) begin
            if (m == 0) begin
                p[1] = 1'b1;
                return sat ? 0 : 999;
            end
            return m - 1;
        end
        return m;
    endfunction

    initial begin
        int          seen;
        int          mw, ms;
        logic [2:0]  pw, ps;
        bit          up_bias;

        reset_n = 1'b0;
        {a_clr, a_load, a_inc, a_dec} = '0; a_val = '0;
        {b_clr, b_load, b_inc, b_dec} = '0; b_val = '0;
        {r_clr, r_load, r_inc, r_dec} = '0; r_val = '0;

        // Reset state
        #2;
        chk("rst_cnt", a_cnt, 16'h0000);
        chk("rst_pulses", {a_wu, a_wd, a_le}, 3'b000);
        chk("rst_zero_max", {a_zero, a_max}, 2'b10);
        chk("rst_cnt_b", b_cnt, 8'h00);
        #1 reset_n = 1'b1;

        // Count up 1000 times
        a_inc = 1'b1;
        seen  = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (a_wu) seen++;
            if (i == 99)  chk("up_0099", a_cnt, 16'h0099);
            if (i == 100) chk("up_0100", a_cnt, 16'h0100);
        end
        chk("up_1000", a_cnt, 16'h1000);
        chk("up_no_wrap", seen, 0);
        a_inc = 1'b0;

        // Wrap at both range ends
        a_load = 1'b1; a_val = 16'h9999;
        step();
        chk("ld_9999", a_cnt, 16'h9999);
        chk("ld_at_max", a_max, 1'b1);
        a_load = 1'b0; a_inc = 1'b1;
        step();
        chk("wrap_cnt", a_cnt, 16'h0000);
        chk("wrap_up_pulse", {a_wu, a_wd, a_le}, 3'b100);
        a_inc = 1'b0;
        step();
        chk("wrap_up_1cyc", a_wu, 1'b0);
        a_dec = 1'b1;
        step();
        chk("wrapdn_cnt", a_cnt, 16'h9999);
        chk("wrap_dn_pulse", {a_wu, a_wd, a_le}, 3'b010);
        a_dec = 1'b0;
        step();
        chk("wrap_dn_1cyc", a_wd, 1'b0);

        // Saturate mode, 2 digits
        b_load = 1'b1; b_val = 8'h99;
        step();
        b_load = 1'b0; b_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_cnt_99", b_cnt, 8'h99);
            chk("sat_up_max", {b_wu, b_max}, 2'b11);
        end
        b_inc = 1'b0;
        step();
        chk("sat_up_end", b_wu, 1'b0);
        b_load = 1'b1; b_val = 8'h00;
        step();
        b_load = 1'b0; b_dec = 1'b1;
        step();
        chk("sat_cnt_00", b_cnt, 8'h00);
        chk("sat_dn", {b_wu, b_wd, b_zero}, 3'b011);
        b_dec = 1'b0;

        // Priority: clr beats load and inc
        a_load = 1'b1; a_val = 16'h0042;
        step();
        chk("ld_0042", a_cnt, 16'h0042);
        a_clr = 1'b1; a_load = 1'b1; a_inc = 1'b1; a_val = 16'h0777;
        step();
        chk("prio_clr", a_cnt, 16'h0000);
        chk("prio_clr_pulses", {a_wu, a_wd, a_le}, 3'b000);
        a_clr = 1'b0;
        // load beats inc
        a_val = 16'h0500;
        step();
        chk("prio_load", a_cnt, 16'h0500);
        // invalid digit rejected
        a_inc = 1'b0; a_val = 16'h12A4;
        step();
        chk("bad_ld_cnt", a_cnt, 16'h0500);
        chk("bad_ld_err", {a_wu, a_wd, a_le}, 3'b001);
        a_load = 1'b0;
        step();
        chk("bad_ld_1cyc", a_le, 1'b0);
        // inc and dec together hold
        a_inc = 1'b1; a_dec = 1'b1;
        step();
        chk("incdec_hold", a_cnt, 16'h0500);
        chk("incdec_pulses", {a_wu, a_wd, a_le}, 3'b000);
        a_inc = 1'b0; a_dec = 1'b0;
        // borrow across digits
        a_dec = 1'b1;
        step();
        chk("borrow_0499", a_cnt, 16'h0499);
        a_dec = 1'b0;

        // Asynchronous reset between edges
        a_load = 1'b1; a_val = 16'h0567;
        step();
        chk("ld_0567", a_cnt, 16'h0567);
        a_load = 1'b0; a_inc = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        chk("arst_cnt", a_cnt, 16'h0000);
        chk("arst_flags", {a_wu, a_wd, a_le, a_zero}, 4'b0001);
        #2 reset_n = 1'b1;
        step();
        chk("arst_resume", a_cnt, 16'h0001);
        a_inc = 1'b0;

        // Random regression against a decimal model, both modes, DIGITS=3
        mw = 0;
        ms = 0;
        for (int i = 0; i < 10000; i++) begin
            up_bias = ((i / 500) % 2) == 0;
            r_clr   = ($urandom_range(0, 31) == 0);
            r_load  = ($urandom_range(0, 7) == 0);
            r_val   = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)),
                       4'($urandom_range(0, 10))};
            if ($urandom_range(0, 7) == 0) r_val = up_bias ? 12'h999 : 12'h000;
            r_inc   = up_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r_dec   = up_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            mw = model(mw, 1'b0, r_clr, r_load, r_val, r_inc, r_dec, pw);
            ms = model(ms, 1'b1, r_clr, r_load, r_val, r_inc, r_dec, ps);
            step();
            chk("rnd_w_cnt", w_cnt, int_to_bcd(mw));
            chk("rnd_w_flags", {w_wu, w_wd, w_le, w_max, w_zero},
                {pw, mw == 999, mw == 0});
            chk("rnd_w_bcd", bcd_ok(w_cnt), 1'b1);
            chk("rnd_s_cnt", s_cnt, int_to_bcd(ms));
            chk("rnd_s_flags", {s_wu, s_wd, s_le, s_max, s_zero},
                {ps, ms == 999, ms == 0});
            chk("rnd_s_bcd", bcd_ok(s_cnt), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
